// File: rtl/hy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hy_cnt
//  Description : Programmable free-running up-counter / tick generator.
//                Counts 0 .. per, wraps to 0 and raises a one-clock
//                period-complete pulse on every wrap. The terminal value is
//                shadowed from cnt_in only at load points, which are the
//                first clock after reset and each terminal count. A change
//                on cnt_in therefore never cuts a running period short.
//
//  Ports       : clk      - system clock, rising-edge active
//                rst_n    - asynchronous, active-low reset
//                cnt_in   - terminal count (period minus 1), quasi-static
//                cnt_out  - current count value, registered
//                cnt_int  - one-cycle period-complete pulse, registered
//                           (named "int" in the original Verilog-2001
//                           source; int is a keyword in SystemVerilog)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hy_cnt #(
    parameter int C_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [C_WIDTH:1] cnt_in,
    output logic [C_WIDTH:1] cnt_out,
    output logic             cnt_int
);

    localparam logic [C_WIDTH:1] c_one = {{(C_WIDTH-1){1'b0}}, 1'b1};

    logic [C_WIDTH:1] r_per;    // shadowed terminal value
    logic             r_armed;  // first period has been loaded
    logic             w_term;   // terminal count reached this cycle

    // The compare runs against the shadow register, so no input reaches an
    // output without passing through a flop.
    assign w_term = r_armed && (cnt_out == r_per);

    // Count, period shadow and arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out <= '0;
            r_per   <= '0;
            r_armed <= 1'b0;
        end else if (!r_armed) begin
            // Load cycle: capture the first period; the count holds at 0.
            r_per   <= cnt_in;
            r_armed <= 1'b1;
        end else if (w_term) begin
            cnt_out <= '0;
            r_per   <= cnt_in;
        end else begin
            // Cannot overflow: terminal is always reached first, even
            // with an all-ones period.
            cnt_out <= cnt_out + c_one;
        end
    end

    // Period-complete pulse, high during the cycle in which the count sits
    // at 0 after a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_int <= 1'b0;
        end else begin
            cnt_int <= w_term;
        end
    end

`ifndef SYNTHESIS
    // History used by the checks below: the previous pulse value and whether
    // the period used for the previous terminal decision was zero.
    logic r_chk_int;
    logic r_chk_per_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_int      <= 1'b0;
            r_chk_per_zero <= 1'b0;
        end else begin
            r_chk_int      <= cnt_int;
            r_chk_per_zero <= (r_per == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Back-to-back pulses only happen with a zero period.
            assert (!(cnt_int && r_chk_int) || r_chk_per_zero);
            // The count never runs past the shadowed terminal value.
            assert (!r_armed || (cnt_out <= r_per));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hy_cnt
//  Description : Directed bench for hy_cnt. A 32-bit instance covers reset,
//                load, wrap timing, sustained periods, mid-period
//                reprogramming, a zero period and an asynchronous mid-count
//                reset. A 4-bit instance covers the all-ones period.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hy_cnt;

    logic        clk;
    logic        rst_n;
    logic [31:0] cnt_in;
    logic [31:0] cnt_out;
    logic        cnt_int;

    logic        rst4_n;
    logic [3:0]  cnt4_in;
    logic [3:0]  cnt4_out;
    logic        cnt4_int;

    int n_pass;
    int n_total;

    hy_cnt #(.C_WIDTH(32)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out),
        .cnt_int (cnt_int)
    );

    hy_cnt #(.C_WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst4_n),
        .cnt_in  (cnt4_in),
        .cnt_out (cnt4_out),
        .cnt_int (cnt4_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until the 32-bit pulse is seen; returns the number of ticks taken.
    task automatic wait_int(input int max_ticks, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cnt_int && n < max_ticks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] exp_cnt;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        rst4_n  = 1'b0;
        cnt_in  = 'x;
        cnt4_in = 'x;

        // Reset state.
        #2;
        check("rst_cnt", cnt_out, 0);
        check("rst_int", cnt_int, 0);
        #10 cnt_in = 32'h0000_00A5;  // t = 12
        #8  rst_n  = 1'b1;           // t = 20

        // Load edge at 25 ns: count and pulse both stay low.
        tick();
        check("load_cnt", cnt_out, 0);
        check("load_int", cnt_int, 0);
        tick();
        check("first_inc", cnt_out, 1);

        // Terminal at the 1675 ns edge, wrap at 1685 ns.
        repeat (164) tick();
        check("term_time", $time, 1676);
        check("term_cnt", cnt_out, 32'hA5);
        check("term_int", cnt_int, 0);
        tick();
        check("wrap_cnt", cnt_out, 0);
        check("wrap_int", cnt_int, 1);
        tick();
        check("post_wrap_cnt", cnt_out, 1);
        check("post_wrap_int", cnt_int, 0);

        // Next pulse at 3345 ns, then 166-clock periods.
        wait_int(400, n);
        check("pulse2_ticks", n, 165);
        check("pulse2_time", $time, 3346);
        for (int i = 0; i < 4; i++) begin
            wait_int(400, n);
            check("period_166", n, 166);
        end

        // Reprogram to 3 while mid-period at 0x10.
        repeat (16) tick();
        check("reprog_at", cnt_out, 32'h10);
        cnt_in = 32'h0000_0003;
        wait_int(400, n);
        check("reprog_old_end", n, 150);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_cnt = (k + 1) % 4;
            check("p4_cnt", cnt_out, exp_cnt);
            check("p4_int", cnt_int, (exp_cnt == 0) ? 1 : 0);
        end

        // Zero period: pulse every cycle after the next wrap.
        tick();
        cnt_in = 32'h0;
        wait_int(10, n);
        check("zero_entry", n, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("zero_cnt", cnt_out, 0);
            check("zero_int", cnt_int, 1);
        end
        cnt_in = 32'h0000_0060;
        tick();
        check("zero_exit_int", cnt_int, 1);
        tick();
        check("zero_exit_cnt", cnt_out, 1);
        check("zero_exit_int2", cnt_int, 0);

        // Asynchronous reset between edges at 0x50.
        repeat (32'h4F) tick();
        check("areset_at", cnt_out, 32'h50);
        #3 rst_n = 1'b0;
        #1;
        check("areset_cnt", cnt_out, 0);
        check("areset_int", cnt_int, 0);
        cnt_in = 32'h0000_0005;
        #1 rst_n = 1'b1;
        tick();
        check("reload_cnt", cnt_out, 0);
        check("reload_int", cnt_int, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("recount_cnt", cnt_out, k);
            check("recount_int", cnt_int, 0);
        end
        tick();
        check("rewrap_cnt", cnt_out, 0);
        check("rewrap_int", cnt_int, 1);

        // 4-bit instance with all-ones period: 16-cycle period.
        @(negedge clk);
        cnt4_in = 4'hF;
        rst4_n  = 1'b1;
        tick();
        check("w4_load_cnt", cnt4_out, 0);
        check("w4_load_int", cnt4_int, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("w4_cnt", cnt4_out, k);
            check("w4_int", cnt4_int, 0);
        end
        tick();
        check("w4_wrap_cnt", cnt4_out, 0);
        check("w4_wrap_int", cnt4_int, 1);
        tick();
        check("w4_after_cnt", cnt4_out, 1);
        check("w4_after_int", cnt4_int, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
